// File: rtl/bf_io_pkg.sv
// bf_io_pkg: shared definitions for the brainfuck stdio bridge.
//   - TX FSM state encodings (legacy-compatible localparams) and the enum
//     built on them.
//   - ASCII constants used by the optional newline expansion
//     (enabled with `define BF_IO_CRLF_EN).
package bf_io_pkg;

  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_CR = 8'h0D;

  localparam logic [1:0] TX_IDLE = 2'd0;
  localparam logic [1:0] TX_SENT = 2'd1;
  localparam logic [1:0] TX_BUSY = 2'd2;

  typedef enum logic [1:0] {
    IDLE = TX_IDLE,
    SENT = TX_SENT,
    BUSY = TX_BUSY
  } tx_state_e;

endpackage

// File: rtl/bf_sync_fifo.sv
// bf_sync_fifo: single-clock circular-buffer FIFO with first-word
// fall-through output.
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   push, din   - write request and data (accepted when not full, or when
//                 full and a pop happens in the same cycle)
//   pop         - read request (ignored while empty)
//   dout        - current head, valid while !empty
//   full, empty - status flags
//   level       - occupancy, 0..DEPTH
module bf_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] LEVEL_FULL = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (level == '0);
  assign full    = (level == LEVEL_FULL);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot the push needs.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

endmodule

// File: rtl/bf_io_bridge.sv
// bf_io_bridge: buffered stdio bridge between the brainfuck core and
// uart_tx / uart_rx. Single clock domain, synchronous active-high reset.
// Optional feature: `define BF_IO_CRLF_EN expands each transmitted LF into
// CR, LF.
// Ports:
//   stdout_data/stdout_en -> TX FIFO (low byte only); stdout_ready = not full
//   uart_tx_data/uart_tx_start/uart_tx_ready - handshake with uart_tx
//   uart_rx_data/uart_rx_valid -> RX FIFO
//   stdin_data/stdin_valid/stdin_rd - fall-through RX head for the core
//   rx_overflow - sticky, a received byte was dropped
//   tx_level    - TX FIFO occupancy
module bf_io_bridge
  import bf_io_pkg::*;
#(
  parameter int unsigned DATA_VALUE_WIDTH = 32,
  parameter int unsigned TX_DEPTH         = 16,
  parameter int unsigned RX_DEPTH         = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DATA_VALUE_WIDTH-1:0]   stdout_data,
  input  logic                          stdout_en,
  output logic                          stdout_ready,
  output logic [7:0]                    uart_tx_data,
  output logic                          uart_tx_start,
  input  logic                          uart_tx_ready,
  input  logic [7:0]                    uart_rx_data,
  input  logic                          uart_rx_valid,
  output logic [7:0]                    stdin_data,
  output logic                          stdin_valid,
  input  logic                          stdin_rd,
  output logic                          rx_overflow,
  output logic [$clog2(TX_DEPTH):0]     tx_level
);

  tx_state_e state;
  logic [7:0] tx_head;
  logic       tx_full;
  logic       tx_empty;
  logic       tx_go;
  logic       tx_pop;
  logic       rx_full;
  logic       rx_empty;
  logic [$clog2(RX_DEPTH):0] rx_level_unused;
  logic       stdout_hi_unused;

  assign stdout_hi_unused = ^stdout_data[DATA_VALUE_WIDTH-1:8];
  assign stdout_ready     = !tx_full;
  assign stdin_valid      = !rx_empty;

  bf_sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (stdout_en && stdout_ready),
    .pop   (tx_pop),
    .din   (stdout_data[7:0]),
    .dout  (tx_head),
    .full  (tx_full),
    .empty (tx_empty),
    .level (tx_level)
  );

  bf_sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (uart_rx_valid),
    .pop   (stdin_rd),
    .din   (uart_rx_data),
    .dout  (stdin_data),
    .full  (rx_full),
    .empty (rx_empty),
    .level (rx_level_unused)
  );

  assign tx_go = (state == IDLE) && !tx_empty && uart_tx_ready;

`ifdef BF_IO_CRLF_EN
  logic cr_done;
  logic send_cr;

  // An LF head is sent twice through IDLE: first as CR (kept in the FIFO),
  // then as itself (popped).
  assign send_cr = (tx_head == ASCII_LF) && !cr_done;
  assign tx_pop  = tx_go && !send_cr;

  always_ff @(posedge clk) begin
    if (reset)      cr_done <= 1'b0;
    else if (tx_go) cr_done <= send_cr;
  end
`else
  assign tx_pop = tx_go;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      uart_tx_start <= 1'b0;
      uart_tx_data  <= '0;
    end else begin
      uart_tx_start <= 1'b0;
      case (state)
        IDLE: if (tx_go) begin
`ifdef BF_IO_CRLF_EN
          uart_tx_data  <= send_cr ? ASCII_CR : tx_head;
`else
          uart_tx_data  <= tx_head;
`endif
          uart_tx_start <= 1'b1;
          state         <= SENT;
        end
        SENT:    if (!uart_tx_ready) state <= BUSY;
        BUSY:    if (uart_tx_ready)  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      rx_overflow <= 1'b0;
    else if (uart_rx_valid && rx_full && !stdin_rd)
      rx_overflow <= 1'b1;
  end

endmodule

// File: tb/tb_bf_io_bridge.sv
`timescale 1ns/1ps
module tb_bf_io_bridge;
  import bf_io_pkg::*;

  localparam int TXD = 16;
  localparam int RXD = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] stdout_data;
  logic        stdout_en;
  logic        stdout_ready;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_start;
  logic        uart_tx_ready;
  logic [7:0]  uart_rx_data;
  logic        uart_rx_valid;
  logic [7:0]  stdin_data;
  logic        stdin_valid;
  logic        stdin_rd;
  logic        rx_overflow;
  logic [4:0]  tx_level;

  always #5 clk = ~clk;

  bf_io_bridge #(.DATA_VALUE_WIDTH(32), .TX_DEPTH(TXD), .RX_DEPTH(RXD)) dut (
    .clk           (clk),
    .reset         (reset),
    .stdout_data   (stdout_data),
    .stdout_en     (stdout_en),
    .stdout_ready  (stdout_ready),
    .uart_tx_data  (uart_tx_data),
    .uart_tx_start (uart_tx_start),
    .uart_tx_ready (uart_tx_ready),
    .uart_rx_data  (uart_rx_data),
    .uart_rx_valid (uart_rx_valid),
    .stdin_data    (stdin_data),
    .stdin_valid   (stdin_valid),
    .stdin_rd      (stdin_rd),
    .rx_overflow   (rx_overflow),
    .tx_level      (tx_level)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // UART transmitter model: busy for 10 cycles after each start pulse.
  logic hold = 1'b0;
  int   busy_cnt = 0;
  always @(posedge clk) begin
    if (uart_tx_start)     busy_cnt <= 10;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign uart_tx_ready = !hold && (busy_cnt == 0);

  // Inputs as sampled by the DUT at each rising edge.
  logic       c_rst, c_en, c_rxv, c_rd;
  logic [7:0] c_dat, c_rxd;
  always @(posedge clk) begin
    c_rst <= reset;
    c_en  <= stdout_en;
    c_dat <= stdout_data[7:0];
    c_rxv <= uart_rx_valid;
    c_rxd <= uart_rx_data;
    c_rd  <= stdin_rd;
  end

  // Behavioural model: queues of bytes held in each direction.
  logic [7:0] q_tx[$];
  logic [7:0] q_rx[$];
  logic [7:0] emitted[$];
  logic       m_ovf = 1'b0;
  logic       m_cr = 1'b0;
  logic       model_on = 1'b0;
  logic       prev_start = 1'b0;
  logic [7:0] prev_data = 8'h00;
  int         starts = 0;

  always @(negedge clk) begin
    int tx_n;
    int rx_n;
    logic [7:0] exp_b;
    if (c_rst === 1'b1) begin
      q_tx.delete();
      q_rx.delete();
      m_ovf    = 1'b0;
      m_cr     = 1'b0;
      model_on = 1'b1;
      chk("rst_start", uart_tx_start, 0);
      chk("rst_tx_data", uart_tx_data, 0);
    end else if (model_on) begin
      tx_n = q_tx.size();
      rx_n = q_rx.size();
      chk("stdout_en_while_full", (c_en && tx_n == TXD), 0);
      chk("start_back_to_back", (prev_start && uart_tx_start), 0);
      if (!uart_tx_start) chk("tx_data_hold", uart_tx_data, prev_data);
      if (uart_tx_start) begin
        starts++;
        emitted.push_back(uart_tx_data);
        if (tx_n == 0) begin
          chk("start_with_empty_fifo", 1, 0);
        end else begin
          exp_b = q_tx[0];
`ifdef BF_IO_CRLF_EN
          if (exp_b == 8'h0A && !m_cr) begin
            exp_b = 8'h0D;
            m_cr  = 1'b1;
          end else begin
            void'(q_tx.pop_front());
            m_cr = 1'b0;
          end
`else
          void'(q_tx.pop_front());
`endif
          chk("tx_byte", uart_tx_data, exp_b);
        end
      end
      if (c_en && tx_n != TXD) q_tx.push_back(c_dat);
      if (c_rd && rx_n > 0) void'(q_rx.pop_front());
      if (c_rxv) begin
        if (rx_n < RXD || c_rd) q_rx.push_back(c_rxd);
        else m_ovf = 1'b1;
      end
    end
    if (model_on) begin
      chk("tx_level", tx_level, q_tx.size());
      chk("stdout_ready", stdout_ready, q_tx.size() != TXD);
      chk("stdin_valid", stdin_valid, q_rx.size() != 0);
      if (q_rx.size() != 0) chk("stdin_data", stdin_data, q_rx[0]);
      chk("rx_overflow", rx_overflow, m_ovf);
    end
    prev_start = uart_tx_start;
    prev_data  = uart_tx_data;
  end

  task automatic cyc(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_start(int bound, string name);
    int k = 0;
    while (!uart_tx_start && k < bound) begin
      cyc(1);
      k++;
    end
    chk(name, uart_tx_start, 1);
  endtask

  task automatic wait_emitted(int n, int bound, string name);
    int k = 0;
    while (emitted.size() < n && k < bound) begin
      cyc(1);
      k++;
    end
    chk(name, emitted.size() >= n, 1);
  endtask

  task automatic tx_write(logic [31:0] v);
    stdout_data = v;
    stdout_en   = 1'b1;
    cyc(1);
    stdout_en   = 1'b0;
  endtask

  initial begin
    int s0;
    reset = 1'b1; stdout_en = 1'b0; stdout_data = '0;
    uart_rx_valid = 1'b0; uart_rx_data = '0; stdin_rd = 1'b0;
    cyc(2);
    chk("reset_tx_level", tx_level, 0);
    chk("reset_stdout_ready", stdout_ready, 1);
    chk("reset_stdin_valid", stdin_valid, 0);
    chk("reset_overflow", rx_overflow, 0);
    chk("reset_tx_data", uart_tx_data, 0);
    reset = 1'b0;
    cyc(1);

    // Single byte: start pulse two cycles after the write strobe.
    tx_write(32'h1234_5641);
    chk("t1_start_not_yet", uart_tx_start, 0);
    chk("t1_level_1", tx_level, 1);
    cyc(1);
    chk("t1_start", uart_tx_start, 1);
    chk("t1_data", uart_tx_data, 8'h41);
    chk("t1_level_0", tx_level, 0);
    cyc(1);
    chk("t1_start_one_cycle", uart_tx_start, 0);
    cyc(20);

    // Fill TX FIFO while UART held busy, then drain in order.
    hold = 1'b1;
    for (int i = 0; i < 16; i++) tx_write(i);
    chk("t2_level_full", tx_level, 16);
    chk("t2_ready_low", stdout_ready, 0);
    emitted.delete();
    hold = 1'b0;
    wait_start(20, "t2_first_start");
    chk("t2_ready_after_pop", stdout_ready, 1);
    chk("t2_level_15", tx_level, 15);
    wait_emitted(16, 400, "t2_drain_timeout");
    for (int i = 0; i < 16; i++)
      if (i < emitted.size()) chk("t2_order", emitted[i], i);
    cyc(15);

    // RX: three bytes in, three pops out, extra pop ignored.
    uart_rx_valid = 1'b1;
    uart_rx_data = 8'h31; cyc(1);
    uart_rx_data = 8'h32; cyc(1);
    uart_rx_data = 8'h33; cyc(1);
    uart_rx_valid = 1'b0;
    chk("t3_valid", stdin_valid, 1);
    chk("t3_head", stdin_data, 8'h31);
    stdin_rd = 1'b1; cyc(1); stdin_rd = 1'b0;
    chk("t3_pop1", stdin_data, 8'h32);
    stdin_rd = 1'b1; cyc(1); stdin_rd = 1'b0;
    chk("t3_pop2", stdin_data, 8'h33);
    stdin_rd = 1'b1; cyc(1); stdin_rd = 1'b0;
    chk("t3_empty", stdin_valid, 0);
    stdin_rd = 1'b1; cyc(1); stdin_rd = 1'b0;
    chk("t3_rd_empty_ignored", stdin_valid, 0);

    // RX full: push+pop same cycle, then a dropped byte.
    uart_rx_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      uart_rx_data = 8'h40 + i[7:0];
      cyc(1);
    end
    uart_rx_valid = 1'b0;
    chk("t4_full_no_ovf", rx_overflow, 0);
    chk("t4_head", stdin_data, 8'h40);
    uart_rx_valid = 1'b1; uart_rx_data = 8'h77; stdin_rd = 1'b1;
    cyc(1);
    uart_rx_valid = 1'b0; stdin_rd = 1'b0;
    chk("t4_pushpop_no_ovf", rx_overflow, 0);
    chk("t4_head_after_pushpop", stdin_data, 8'h41);
    uart_rx_valid = 1'b1; uart_rx_data = 8'hEE;
    cyc(1);
    uart_rx_valid = 1'b0;
    chk("t4_overflow", rx_overflow, 1);
    for (int i = 0; i < 16; i++) begin
      chk("t4_drain", stdin_data, (i < 15) ? (8'h41 + i) : 8'h77);
      stdin_rd = 1'b1; cyc(1); stdin_rd = 1'b0;
    end
    chk("t4_drained", stdin_valid, 0);
    cyc(3);
    chk("t4_overflow_sticky", rx_overflow, 1);

    // Reset while the FSM waits in BUSY with 5 bytes queued.
    for (int i = 0; i < 6; i++) tx_write(32'hA0 + i);
    cyc(2);
    chk("t5_level_5", tx_level, 5);
    reset = 1'b1; cyc(1); reset = 1'b0;
    chk("t5_level_0", tx_level, 0);
    chk("t5_ready", stdout_ready, 1);
    chk("t5_ovf_clear", rx_overflow, 0);
    chk("t5_no_start", uart_tx_start, 0);
    s0 = starts;
    cyc(30);
    chk("t5_no_more_starts", starts - s0, 0);

    // "A\n": newline expansion depends on the build.
    emitted.delete();
    tx_write(32'h41);
    tx_write(32'h0A);
`ifdef BF_IO_CRLF_EN
    wait_emitted(3, 200, "t6_timeout");
    cyc(20);
    chk("t6_count", emitted.size(), 3);
    if (emitted.size() >= 3) begin
      chk("t6_b0", emitted[0], 8'h41);
      chk("t6_b1", emitted[1], 8'h0D);
      chk("t6_b2", emitted[2], 8'h0A);
    end
`else
    wait_emitted(2, 200, "t6_timeout");
    cyc(20);
    chk("t6_count", emitted.size(), 2);
    if (emitted.size() >= 2) begin
      chk("t6_b0", emitted[0], 8'h41);
      chk("t6_b1", emitted[1], 8'h0A);
    end
`endif
    chk("t6_level_0", tx_level, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
